// File: rtl/pulse_sequencer.sv
// Sequences up to N_CH pulse channels: per-channel start delay, completion handshake,
// repeated bursts separated by a gap, and a timeout watchdog on each channel.
module pulse_sequencer #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk_Seq,
  input  logic             rst_n,
  input  logic             arm_i,
  input  logic             trig_i,
  input  logic             abort_i,
  input  logic             cfg_we_i,
  input  logic [2:0]       cfg_addr_i,
  input  logic [CNT_W-1:0] cfg_data_i,
  input  logic [N_CH-1:0]  ch_done_i,
  output logic [N_CH-1:0]  ch_start_o,
  output logic             busy_o,
  output logic             seq_done_o,
  output logic             err_tmo_o,
  output logic [7:0]       shot_cnt_o
);

  localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {StIdle, StDelay, StWait, StGap} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic             seen_low_q, seen_low_d;
  logic [N_CH-1:0]  ch_start_q, ch_start_d;
  logic             seq_done_q, seq_done_d;
  logic             err_q, err_d;
  logic [7:0]       shot_q, shot_d;
  logic             trig_q;

  logic [CNT_W-1:0] delay_q [N_CH];
  logic [N_CH-1:0]  mask_q;
  logic [CNT_W-1:0] tmo_q, rep_q, gap_q;

  logic             cfg_wr, trig_rise, burst_end;
  logic [ChW:0]     first, nxt;

  // Lowest enabled channel at index >= from; MSB flags that one was found.
  function automatic logic [ChW:0] find_from(input logic [N_CH-1:0] mask, input int from);
    logic [ChW:0] r;
    r = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) r = {1'b1, i[ChW-1:0]};
    end
    return r;
  endfunction

  assign cfg_wr    = cfg_we_i && (state_q == StIdle);
  assign trig_rise = trig_i && !trig_q;
  assign first     = find_from(mask_q, 0);
  assign nxt       = find_from(mask_q, int'(ch_q) + 1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    ch_d       = ch_q;
    seen_low_d = seen_low_q;
    ch_start_d = ch_start_q;
    seq_done_d = 1'b0;
    err_d      = err_q;
    shot_d     = shot_q;
    burst_end  = 1'b0;

    if (cfg_wr && (cfg_addr_i == 3'd5)) err_d = 1'b0;

    if (abort_i) begin
      state_d    = StIdle;
      ch_start_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig_rise && arm_i && first[ChW]) begin
            state_d = StDelay;
            ch_d    = first[ChW-1:0];
            cnt_d   = delay_q[first[ChW-1:0]];
            rem_d   = (rep_q == '0) ? CNT_W'(1) : rep_q;
          end
        end
        StDelay: begin
          if (cnt_q == '0) begin
            state_d          = StWait;
            ch_start_d       = '0;
            ch_start_d[ch_q] = 1'b1;
            cnt_d            = '0;
            seen_low_d       = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StWait: begin
          // A done must be seen low first so a stale done from the last burst is ignored.
          seen_low_d = seen_low_q | ~ch_done_i[ch_q];
          if (ch_done_i[ch_q] && seen_low_q) begin
            ch_start_d = '0;
            if (nxt[ChW]) begin
              state_d = StDelay;
              ch_d    = nxt[ChW-1:0];
              cnt_d   = delay_q[nxt[ChW-1:0]];
            end else begin
              burst_end = 1'b1;
            end
          end else if ((tmo_q != '0) && (cnt_q == tmo_q)) begin
            ch_start_d = '0;
            err_d      = 1'b1;
            state_d    = StIdle;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            state_d = StDelay;
            ch_d    = first[ChW-1:0];
            cnt_d   = delay_q[first[ChW-1:0]];
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      endcase

      if (burst_end) begin
        shot_d = shot_q + 8'd1;
        if (rem_q > CNT_W'(1)) begin
          rem_d   = rem_q - CNT_W'(1);
          cnt_d   = gap_q;
          state_d = StGap;
        end else begin
          seq_done_d = 1'b1;
          state_d    = StIdle;
        end
      end
    end
  end

  always_ff @(posedge clk_Seq or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      ch_q       <= '0;
      seen_low_q <= 1'b0;
      ch_start_q <= '0;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
      shot_q     <= '0;
      trig_q     <= 1'b1;
      mask_q     <= N_CH'(1);
      tmo_q      <= '0;
      rep_q      <= CNT_W'(1);
      gap_q      <= '0;
      for (int i = 0; i < int'(N_CH); i++) delay_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      ch_q       <= ch_d;
      seen_low_q <= seen_low_d;
      ch_start_q <= ch_start_d;
      seq_done_q <= seq_done_d;
      err_q      <= err_d;
      shot_q     <= shot_d;
      trig_q     <= trig_i;
      if (cfg_wr) begin
        case (cfg_addr_i)
          3'd4:    mask_q <= cfg_data_i[N_CH-1:0];
          3'd5:    tmo_q  <= cfg_data_i;
          3'd6:    rep_q  <= cfg_data_i;
          3'd7:    gap_q  <= cfg_data_i;
          default: begin
            if ({29'd0, cfg_addr_i} < N_CH) delay_q[cfg_addr_i[ChW-1:0]] <= cfg_data_i;
          end
        endcase
      end
    end
  end

  assign ch_start_o = ch_start_q;
  assign busy_o     = (state_q != StIdle);
  assign seq_done_o = seq_done_q;
  assign err_tmo_o  = err_q;
  assign shot_cnt_o = shot_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: a channel model answers ch_start, and a scoreboard of expected
// start rises, seq_done pulses and timeout errors (with cycle stamps) is matched by a monitor.
module tb_pulse_sequencer;

  localparam int N_CH  = 4;
  localparam int CNT_W = 17;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             arm      = 1'b0;
  logic             trig     = 1'b0;
  logic             abort    = 1'b0;
  logic             cfg_we   = 1'b0;
  logic [2:0]       cfg_addr = '0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic [N_CH-1:0]  ch_done  = '0;
  logic [N_CH-1:0]  ch_start;
  logic             busy, seq_done, err_tmo;
  logic [7:0]       shot_cnt;

  always #5 clk = ~clk;

  pulse_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk_Seq   (clk),
    .rst_n     (rst_n),
    .arm_i     (arm),
    .trig_i    (trig),
    .abort_i   (abort),
    .cfg_we_i  (cfg_we),
    .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data),
    .ch_done_i (ch_done),
    .ch_start_o(ch_start),
    .busy_o    (busy),
    .seq_done_o(seq_done),
    .err_tmo_o (err_tmo),
    .shot_cnt_o(shot_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference copy of the configuration, updated only for writes made while idle.
  int m_delay [N_CH] = '{0, 0, 0, 0};
  int m_mask  = 1;
  int m_tmo   = 0;
  int m_rep   = 1;
  int m_gap   = 0;
  int m_shot  = 0;
  int lat      = 10;
  int hold_len = 0;

  // Event kinds: 0 = ch_start rise, 1 = seq_done pulse, 2 = err_tmo rise.
  typedef struct {int kind; int ch; int cyc;} ev_t;
  ev_t exp_q[$];

  task automatic push_ev(input int kind, input int ch, input int at);
    ev_t e;
    e.kind = kind;
    e.ch   = ch;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Channel model: done rises once start has been seen for lat cycles, lingers hold_len after.
  int run_c  [N_CH] = '{default: 0};
  int hold_c [N_CH] = '{default: 0};
  logic [N_CH-1:0] cm_prev = '0;

  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (ch_start[i]) run_c[i]++;
      else run_c[i] = 0;
      if (cm_prev[i] && !ch_start[i]) hold_c[i] = hold_len;
      else if (hold_c[i] > 0) hold_c[i]--;
      ch_done[i] = (ch_start[i] && run_c[i] >= lat) || (hold_c[i] > 0);
    end
    cm_prev = ch_start;
  end

  task automatic mon_event(input int kind, input int ch);
    ev_t e;
    check("event_expected", int'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_ch", ch, e.ch);
      check("ev_cycle", cyc, e.cyc);
    end
  endtask

  logic [N_CH-1:0] mon_prev = '0;
  logic            err_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_start[i] && !mon_prev[i]) begin
          check("start_onehot", $countones(ch_start), 1);
          mon_event(0, i);
        end
      end
      if (seq_done) mon_event(1, 0);
      if (err_tmo && !err_prev) mon_event(2, 0);
    end
    mon_prev = ch_start;
    err_prev = err_tmo;
  end

  task automatic cfg_write(input int addr, input int data, input bit track);
    cfg_we   = 1'b1;
    cfg_addr = addr[2:0];
    cfg_data = data[CNT_W-1:0];
    @(negedge clk);
    cfg_we = 1'b0;
    if (track) begin
      case (addr)
        4:       m_mask = data;
        5:       m_tmo  = data;
        6:       m_rep  = data;
        7:       m_gap  = data;
        default: m_delay[addr] = data;
      endcase
    end
  endtask

  task automatic fire(output int n);
    trig = 1'b1;
    n    = cyc;
    @(negedge clk);
    trig = 1'b0;
  endtask

  // Expected rise/done stamps for a full sequence triggered at the negedge stamped n.
  task automatic push_seq(input int n);
    int chs [N_CH];
    int k, bursts, m, tc;
    k = 0;
    for (int c = 0; c < N_CH; c++) if (m_mask[c]) begin chs[k] = c; k++; end
    bursts = (m_rep == 0) ? 1 : m_rep;
    m = n + 2 + m_delay[chs[0]];
    for (int b = 0; b < bursts; b++) begin
      for (int j = 0; j < k; j++) begin
        push_ev(0, chs[j], m);
        tc = m + lat;
        if (j < k - 1) m = tc + 1 + m_delay[chs[j+1]];
        else if (b < bursts - 1) m = tc + 2 + m_gap + m_delay[chs[0]];
        else push_ev(1, 0, tc);
      end
    end
    m_shot = (m_shot + bursts) % 256;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < max) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_in_time"}, int'(w < max), 1);
    exp_q.delete();
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1);
  end

  initial begin
    int n, target;
    arm  = 1'b1;
    trig = 1'b1;
    idle_cycles(3);
    check("rst_ch_start", ch_start, 0);
    check("rst_busy", busy, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_err", err_tmo, 0);
    check("rst_shot", shot_cnt, 0);
    rst_n = 1'b1;
    idle_cycles(6);
    check("trig_high_thru_reset", busy, 0);
    trig = 1'b0;
    idle_cycles(2);

    // Disarmed trigger, then empty mask: neither may start.
    arm = 1'b0;
    fire(n);
    idle_cycles(6);
    check("disarmed_no_start", busy, 0);
    arm = 1'b1;
    cfg_write(4, 0, 1);
    fire(n);
    idle_cycles(6);
    check("mask0_no_start", busy, 0);

    // Two channels with delays, single burst.
    cfg_write(4, 5, 1);
    cfg_write(0, 3, 1);
    cfg_write(2, 5, 1);
    cfg_write(6, 1, 1);
    lat = 10; hold_len = 0;
    fire(n);
    push_seq(n);
    wait_idle("two_ch", 200);
    check("two_ch_shot", shot_cnt, m_shot);

    // Three bursts separated by a gap; done lingers after start drops.
    cfg_write(4, 1, 1);
    cfg_write(6, 3, 1);
    cfg_write(7, 4, 1);
    hold_len = 2;
    fire(n);
    push_seq(n);
    wait_idle("repeat", 300);
    check("repeat_shot", shot_cnt, m_shot);

    // No gap and a long-lingering done: the stale done must not complete the next burst.
    cfg_write(0, 0, 1);
    cfg_write(6, 2, 1);
    cfg_write(7, 0, 1);
    hold_len = 6;
    fire(n);
    push_seq(n);
    wait_idle("stale", 300);
    check("stale_shot", shot_cnt, m_shot);

    // Trigger edge and config write while busy are both dropped.
    cfg_write(0, 3, 1);
    cfg_write(6, 1, 1);
    hold_len = 0;
    fire(n);
    push_seq(n);
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    cfg_write(0, 9, 0);
    wait_idle("busy_ignore", 200);
    idle_cycles(4);
    fire(n);
    push_seq(n);
    wait_idle("busy_write_dropped", 200);
    check("busy_ignore_shot", shot_cnt, m_shot);

    // Timeout on a channel that never completes, then clear by writing the timeout register.
    cfg_write(5, 20, 1);
    lat = 1_000_000;
    fire(n);
    push_ev(0, 0, n + 2 + m_delay[0]);
    push_ev(2, 0, n + 2 + m_delay[0] + 1 + m_tmo);
    wait_idle("timeout", 200);
    check("tmo_err", err_tmo, 1);
    check("tmo_busy", busy, 0);
    check("tmo_ch_start", ch_start, 0);
    check("tmo_shot", shot_cnt, m_shot);
    cfg_write(5, 0, 1);
    check("tmo_err_cleared", err_tmo, 0);

    // Abort in the same cycle as a qualifying done on channel 0.
    cfg_write(4, 5, 1);
    lat = 10;
    fire(n);
    push_ev(0, 0, n + 2 + m_delay[0]);
    target = n + 2 + m_delay[0] + lat - 1;
    while (cyc < target) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("abort", 100);
    idle_cycles(20);
    check("abort_ch_start", ch_start, 0);
    check("abort_busy", busy, 0);
    check("abort_shot", shot_cnt, m_shot);
    check("abort_err", err_tmo, 0);

    // Run the counter up to 255, then one more burst (repeat 0 acts as 1) to wrap it.
    cfg_write(4, 1, 1);
    cfg_write(0, 0, 1);
    cfg_write(7, 0, 1);
    cfg_write(6, 255 - m_shot, 1);
    lat = 2;
    fire(n);
    push_seq(n);
    wait_idle("to_255", 3000);
    check("shot_255", shot_cnt, 255);
    cfg_write(6, 0, 1);
    fire(n);
    push_seq(n);
    wait_idle("wrap", 100);
    check("shot_wrap", shot_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
